// File: rtl/bin2bcd_iter.sv
// Iterative binary-to-BCD converter (shift-add-3), one shared datapath, WIDTH cycles per word.
// Optional signed operand mode: define BIN2BCD_SIGNED_EN.
module bin2bcd_iter #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic                  out_neg,
  output logic                  out_ovf,
  output logic                  busy,
  output logic [1:0]            o_dbg_state
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high; the producer holds data stable while valid is high and ready is low.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shift;
  logic [BW-1:0]    r_scratch;
  logic [CW-1:0]    r_count;
  logic             r_ovf_sticky;
  logic [BW-1:0]    r_out_bcd;
  logic             r_out_ovf;
  logic             r_out_valid;

  logic [BW-1:0]    w_adj;
  logic [BW-1:0]    w_scratch_nxt;
  logic [WIDTH-1:0] w_shift_nxt;
  logic [WIDTH-1:0] w_operand;
  logic             w_carry;
  logic             w_last;

  always_comb begin
    w_adj = r_scratch;
    for (int d = 0; d < DIGITS; d++) begin
      if (r_scratch[4*d +: 4] >= 4'd5) begin
        w_adj[4*d +: 4] = r_scratch[4*d +: 4] + 4'd3;
      end
    end
  end

  // The bit leaving the top digit is lost from the scratch, so it marks overflow.
  assign w_carry       = w_adj[BW-1];
  assign w_scratch_nxt = {w_adj[BW-2:0], r_shift[WIDTH-1]};
  assign w_shift_nxt   = {r_shift[WIDTH-2:0], 1'b0};
  assign w_last        = (r_count == CW'(1));

`ifdef BIN2BCD_SIGNED_EN
  logic r_neg_pend;
  logic r_out_neg;

  // Magnitude kept at WIDTH bits unsigned so the most negative value is exact.
  assign w_operand = in_data[WIDTH-1] ? ((~in_data) + WIDTH'(1)) : in_data;
  assign out_neg   = r_out_neg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_neg_pend <= 1'b0;
      r_out_neg  <= 1'b0;
    end else begin
      if (r_state == S_IDLE && in_valid) begin
        r_neg_pend <= in_data[WIDTH-1];
      end
      if (r_state == S_SHIFT && w_last) begin
        r_out_neg <= r_neg_pend;
      end
    end
  end
`else
  assign w_operand = in_data;
  assign out_neg   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_shift      <= '0;
      r_scratch    <= '0;
      r_count      <= '0;
      r_ovf_sticky <= 1'b0;
      r_out_bcd    <= '0;
      r_out_ovf    <= 1'b0;
      r_out_valid  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_shift      <= w_operand;
            r_scratch    <= '0;
            r_ovf_sticky <= 1'b0;
            r_count      <= CW'(WIDTH);
            r_state      <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_scratch    <= w_scratch_nxt;
          r_shift      <= w_shift_nxt;
          r_ovf_sticky <= r_ovf_sticky | w_carry;
          r_count      <= r_count - CW'(1);
          if (w_last) begin
            r_out_bcd   <= w_scratch_nxt;
            r_out_ovf   <= r_ovf_sticky | w_carry;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready    = (r_state == S_IDLE);
  assign busy        = (r_state != S_IDLE);
  assign out_valid   = r_out_valid;
  assign out_bcd     = r_out_bcd;
  assign out_ovf     = r_out_ovf;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_bin2bcd_iter.sv
// Directed + random bench for bin2bcd_iter: a 3-digit and a 2-digit instance share stimulus.
module tb_bin2bcd_iter;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        out_ready;

  logic        in_ready,  out_valid,  out_neg,  out_ovf,  busy;
  logic [11:0] out_bcd;
  logic [1:0]  dbg_state;
  logic        in_ready2, out_valid2, out_neg2, out_ovf2, busy2;
  logic [7:0]  out_bcd2;
  logic [1:0]  dbg_state2;

  logic [13:0] exp_q[$];
  logic [13:0] exp2_q[$];
  int tests = 0;
  int fails = 0;

  bin2bcd_iter #(.WIDTH(8), .DIGITS(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_bcd(out_bcd), .out_neg(out_neg), .out_ovf(out_ovf), .busy(busy),
    .o_dbg_state(dbg_state)
  );

  bin2bcd_iter #(.WIDTH(8), .DIGITS(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .in_data(in_data), .out_valid(out_valid2), .out_ready(out_ready),
    .out_bcd(out_bcd2), .out_neg(out_neg2), .out_ovf(out_ovf2), .busy(busy2),
    .o_dbg_state(dbg_state2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // Reference: {neg, ovf, bcd} computed arithmetically from the operand.
  function automatic logic [13:0] model(input logic [7:0] d, input int digits);
    int mag;
    int p;
    logic neg;
    logic [11:0] bcd;
`ifdef BIN2BCD_SIGNED_EN
    neg = d[7];
    mag = neg ? (256 - int'(d)) : int'(d);
`else
    neg = 1'b0;
    mag = int'(d);
`endif
    p = 1;
    bcd = '0;
    for (int i = 0; i < digits; i++) begin
      bcd[4*i +: 4] = 4'((mag / p) % 10);
      p = p * 10;
    end
    return {neg, (mag >= p), bcd};
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input bit keep);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", 16'(n < 40), 16'd1);
    exp_q.push_back(model(d, 3));
    exp2_q.push_back(model(d, 2));
    @(negedge clk);
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag);
    int k;
    bit rdy_seen;
    logic [13:0] e;
    logic [13:0] e2;
    k = 0;
    rdy_seen = 1'b0;
    while (!out_valid && k < 40) begin
      if (in_ready) rdy_seen = 1'b1;
      @(negedge clk);
      k++;
    end
    chk({tag, "_latency"}, 16'(k), 16'd8);
    chk({tag, "_ready_low"}, 16'(rdy_seen), 16'd0);
    chk({tag, "_state"}, 16'(dbg_state), 16'd2);
    if (exp_q.size() == 0 || exp2_q.size() == 0) begin
      chk({tag, "_queue"}, 16'd0, 16'd1);
    end else begin
      e  = exp_q.pop_front();
      e2 = exp2_q.pop_front();
      chk({tag, "_bcd"}, 16'(out_bcd), 16'(e[11:0]));
      chk({tag, "_ovf"}, 16'(out_ovf), 16'(e[12]));
      chk({tag, "_neg"}, 16'(out_neg), 16'(e[13]));
      chk({tag, "_d2_valid"}, 16'(out_valid2), 16'd1);
      chk({tag, "_d2_bcd"}, 16'(out_bcd2), 16'(e2[7:0]));
      chk({tag, "_d2_ovf"}, 16'(out_ovf2), 16'(e2[12]));
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'd0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 16'(in_ready), 16'd1);
    chk("rst_out_valid", 16'(out_valid), 16'd0);
    chk("rst_out_bcd", 16'(out_bcd), 16'd0);
    chk("rst_ovf_neg_busy", {13'd0, out_ovf, out_neg, busy}, 16'd0);

    // Full-scale unsigned value, result retained after handshake.
    send(8'd255, 1'b0);
    wait_out("t1");
    chk("t1_literal", 16'(out_bcd), 16'h255);
    @(negedge clk);
    chk("t1_post_valid", 16'(out_valid), 16'd0);
    chk("t1_post_hold", 16'(out_bcd), 16'h255);
    chk("t1_post_ready", 16'(in_ready), 16'd1);

    // Back-to-back with in_valid held high.
    send(8'd0, 1'b1);   wait_out("t2_0");
    send(8'd9, 1'b1);   wait_out("t2_9");
    send(8'd99, 1'b1);  wait_out("t2_99");
    send(8'd100, 1'b0); wait_out("t2_100");
    chk("t2_literal", 16'(out_bcd), 16'h100);
    @(negedge clk);

    // Consumer stalls; in_valid pulses in DONE must be ignored.
    out_ready = 1'b0;
    send(8'd173, 1'b0);
    wait_out("t3");
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      in_data  = 8'd11;
      @(negedge clk);
      chk("t3_hold_valid", 16'(out_valid), 16'd1);
      chk("t3_hold_bcd", 16'(out_bcd), 16'h173);
      chk("t3_hold_ready", 16'(in_ready), 16'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("t3_release_valid", 16'(out_valid), 16'd0);
    @(negedge clk);
    chk("t3_no_queue", 16'(busy), 16'd0);

    // Asynchronous reset mid-conversion.
    send(8'd200, 1'b0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("t4_rst_valid", 16'(out_valid), 16'd0);
    chk("t4_rst_bcd", 16'(out_bcd), 16'd0);
    chk("t4_rst_flags", {13'd0, out_ovf, out_neg, busy}, 16'd0);
    void'(exp_q.pop_back());
    void'(exp2_q.pop_back());
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t4_ready", 16'(in_ready), 16'd1);
    send(8'd42, 1'b0);
    wait_out("t4_42");
    @(negedge clk);

    // Overflow on the 2-digit instance.
    send(8'd200, 1'b0);
    wait_out("t5_200");
    chk("t5_d2_ovf_lit", {8'd0, out_ovf2, 7'd0}, 16'h0080);
    @(negedge clk);
    send(8'd57, 1'b0);
    wait_out("t5_57");
    @(negedge clk);

    // Sign-boundary operands (signed mode checks neg/magnitude).
    send(8'h80, 1'b0); wait_out("t6_80"); @(negedge clk);
    send(8'hFF, 1'b0); wait_out("t6_ff"); @(negedge clk);
    send(8'h7F, 1'b0); wait_out("t6_7f"); @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      send(8'($urandom_range(0, 255)), 1'b0);
      wait_out("rand");
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
